dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
Two-port arbiter and sequencer in front of the single-port word-wide data memory `dm`. `dm` has a combinational read, a posedge write, and whole-word write only.
- Shares `dm` between master 0 (CPU data port) and master 1 (DMA/debug port) using round-robin arbitration.
- Converts byte-enabled writes into read-modify-write sequences.
- Returns read data through a req/ack handshake.

Parameters:
AW, 10, word-address width (matches dm addr[11:2])
DW, 32, data width; byte lanes = DW/8 (fixed 4)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
m0_req  in  1  master 0 request, held until m0_ack
m0_we  in  1  1 = write, 0 = read
m0_be  in  4  byte enables; be[0] = bits 7:0, be[3] = bits 31:24
m0_addr  in  AW  word address
m0_wdata  in  DW  write data
m0_ack  out  1  one-cycle completion pulse
m0_rdata  out  DW  read data, valid while m0_ack = 1
m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_ack, m1_rdata  same as m0_*, for master 1
dm_addr  out  AW  to dm addr
dm_din  out  DW  to dm din
dm_we  out  1  to dm dm_we
dm_dout  in  DW  from dm dout (combinational read)

Behaviour:
Reset (rst_n low, takes effect immediately):
- state = IDLE; last_grant = 1, so m0 wins the first tie.
- Latched addr/we/be/wdata cleared; rdata_q = 0.
- All outputs 0: m0_ack, m1_ack, m0_rdata, m1_rdata, dm_addr, dm_din, dm_we.

Shared outputs:
- m0_rdata and m1_rdata are both driven from rdata_q.
- dm_addr is always the latched address (addr_q).
- dm_we is decoded from state only; it is never driven from an input.

States: IDLE, ACCESS, MERGE_WR, ACK.

IDLE:
- If no req is high, stay in IDLE.
- If exactly one req is high, grant that master.
- If both reqs are high, grant the master != last_grant.
- On grant: latch the granted master's addr/we/be/wdata into addr_q/we_q/be_q/wdata_q and its id into gnt_q; go to ACCESS.

ACCESS:
- Read (we_q = 0): rdata_q <= dm_dout; go to ACK.
- Write with be_q = 4'b1111: dm_we = 1, dm_din = wdata_q; go to ACK.
- Write with be_q = 4'b0000: no dm_we; go to ACK.
- Any other write: merge_q <= dm_dout; go to MERGE_WR.

MERGE_WR:
- dm_we = 1.
- dm_din lane i = be_q[i] ? wdata_q lane i : merge_q lane i.
- Go to ACK.

ACK:
- m<gnt_q>_ack = 1 for exactly one cycle; the other master's ack stays 0.
- last_grant <= gnt_q; go to IDLE.

Latency (req first seen high at edge t, in IDLE):
- Read, full write, be = 0 write: ack high in cycle t+2.
- Partial write: ack high in cycle t+3.
- Minimum back-to-back spacing is therefore 3 cycles.

Handshake rules:
- Master holds req, we, be, addr, wdata stable until it sees ack.
- A req still high in IDLE after ack is treated as a new request.
- The two acks are never high together.

Other rules:
- dm_we is high for at most one cycle per transaction, never in IDLE or ACK.
- Under continuous requests from both masters, grants strictly alternate.
- A non-requesting master's inputs are ignored.
- Reset mid-transaction: FSM aborts immediately, dm_we drops asynchronously, no ack is issued.
- If reset hits ACCESS of a partial write, memory is unmodified.
- Addresses wrap naturally within AW bits; there are no out-of-range cases.

Test Plan:
1. Hold rst_n = 0, raise both reqs, release reset -> all outputs 0 during reset; first grant goes to m0 (m0_ack at t+2, m1_ack stays 0).
2. m0 write addr 0x004, wdata 0xDEADBEEF, be 1111 -> dm_we high one cycle in ACCESS, m0_ack at t+2. Then m1 read addr 0x004 -> m1_rdata = 0xDEADBEEF with m1_ack at t+2.
3. Preload mem[5] = 0x11223344; m1 write addr 5, be 0011, wdata 0xAABBCCDD -> dm_din = 0x1122CCDD, dm_we exactly one cycle (MERGE_WR), m1_ack at t+3, mem[5] = 0x1122CCDD.
4. Both masters request reads continuously for 6 transactions -> ack order m0,m1,m0,m1,m0,m1, 3 cycles apart, never overlapping.
5. Repeat scenario 3 and pulse rst_n low during ACCESS -> mem[5] stays 0x11223344, no ack, dm_we stays 0; after release FSM is in IDLE and accepts a new read normally.
6. m0 write be 0000 to addr 7 holding 0xCAFEF00D -> dm_we never asserted, m0_ack at t+2, mem[7] unchanged.

Source files
------------

// File: rtl/dm_arbiter.sv
// Round-robin two-master arbiter in front of a single-port word memory.
// Byte-enabled partial writes become read-modify-write sequences.
module dm_arbiter #(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [DW/8-1:0] m0_be,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [DW/8-1:0] m1_be,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_we,
  input  logic [DW-1:0] dm_dout
);

  localparam int unsigned NB = DW / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, ACK} state_e;

  state_e          state_q;
  logic            last_q;
  logic            gnt_q;
  logic            we_q;
  logic [NB-1:0]   be_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   merge_q;
  logic [DW-1:0]   rdata_q;

  logic            gnt_valid_c;
  logic            gnt_id_c;
  logic            be_full_c;
  logic            be_none_c;
  logic [DW-1:0]   merged_c;

  // Arbitration: a lone requester wins; on a tie the master not granted last wins.
  always_comb begin
    gnt_valid_c = m0_req | m1_req;
    gnt_id_c    = 1'b0;
    if (m0_req && m1_req) begin
      gnt_id_c = ~last_q;
    end else begin
      gnt_id_c = m1_req;
    end
  end

  assign be_full_c = (be_q == {NB{1'b1}});
  assign be_none_c = (be_q == {NB{1'b0}});

  // Enabled lanes take new data, the rest keep the word read in ACCESS.
  always_comb begin
    merged_c = merge_q;
    for (int unsigned i = 0; i < NB; i++) begin
      if (be_q[i]) begin
        merged_c[i*8 +: 8] = wdata_q[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid_c) begin
            gnt_q   <= gnt_id_c;
            we_q    <= gnt_id_c ? m1_we    : m0_we;
            be_q    <= gnt_id_c ? m1_be    : m0_be;
            addr_q  <= gnt_id_c ? m1_addr  : m0_addr;
            wdata_q <= gnt_id_c ? m1_wdata : m0_wdata;
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rdata_q <= dm_dout;
            state_q <= ACK;
          end else if (be_full_c || be_none_c) begin
            state_q <= ACK;
          end else begin
            merge_q <= dm_dout;
            state_q <= MERGE_WR;
          end
        end
        MERGE_WR: begin
          state_q <= ACK;
        end
        ACK: begin
          last_q  <= gnt_q;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Memory strobes decode from state so reset drops them immediately.
  always_comb begin
    dm_we  = 1'b0;
    dm_din = '0;
    if (state_q == MERGE_WR) begin
      dm_we  = 1'b1;
      dm_din = merged_c;
    end else if (state_q == ACCESS && we_q && be_full_c) begin
      dm_we  = 1'b1;
      dm_din = wdata_q;
    end
  end

  assign dm_addr  = addr_q;
  assign m0_ack   = (state_q == ACK) && !gnt_q;
  assign m1_ack   = (state_q == ACK) &&  gnt_q;
  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural word memory behind it.
module tb_dm_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  int checks;
  int errors;

  dm_arbiter #(.AW(10), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we), .dm_dout(dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_dout = mem[dm_addr];

  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_din;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  // Advance one clock; outputs are observed on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd3; m0_be = 4'hF;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 10'd9; m1_be = 4'hF;
    m1_wdata = 32'h0BAD_0BAD;
    step(); step();
    checks++;
    if ({m0_ack, m1_ack, dm_we} !== 3'b000 || dm_addr !== 10'd0 || dm_din !== 32'd0
        || m0_rdata !== 32'd0 || m1_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: ack0=%b ack1=%b we=%b addr=%h din=%h rd0=%h rd1=%h required all 0",
               m0_ack, m1_ack, dm_we, dm_addr, dm_din, m0_rdata, m1_rdata);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (dm_addr !== 10'd3 || m0_ack !== 1'b0 || dm_we !== 1'b0) begin
      errors++;
      $display("FAIL first_grant_addr: addr=%h ack0=%b we=%b required addr=003 ack0=0 we=0",
               dm_addr, m0_ack, dm_we);
    end
    step();
    checks++;
    if (m0_ack !== 1'b1 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL first_grant_ack: ack0=%b ack1=%b required 1 0", m0_ack, m1_ack);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
  endtask

  task automatic test_full_write_read();
    m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'hF; m0_addr = 10'h004; m0_wdata = 32'hDEADBEEF;
    step();
    checks++;
    if (dm_we !== 1'b1 || dm_din !== 32'hDEADBEEF || m0_ack !== 1'b0) begin
      errors++;
      $display("FAIL full_write_access: we=%b din=%h ack0=%b required 1 deadbeef 0",
               dm_we, dm_din, m0_ack);
    end
    step();
    checks++;
    if (m0_ack !== 1'b1 || dm_we !== 1'b0 || mem[4] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL full_write_ack: ack0=%b we=%b mem4=%h required 1 0 deadbeef",
               m0_ack, dm_we, mem[4]);
    end
    m0_req = 1'b0;
    step();
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'h004; m1_be = 4'h0;
    step();
    checks++;
    if (dm_we !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL read_access: we=%b ack1=%b required 0 0", dm_we, m1_ack);
    end
    step();
    checks++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_ack: ack1=%b ack0=%b rdata=%h required 1 0 deadbeef",
               m1_ack, m0_ack, m1_rdata);
    end
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_partial_write();
    preload(10'd5, 32'h11223344);
    m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'b0011; m1_addr = 10'd5; m1_wdata = 32'hAABBCCDD;
    step();
    checks++;
    if (dm_we !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL partial_access: we=%b ack1=%b required 0 0", dm_we, m1_ack);
    end
    step();
    checks++;
    if (dm_we !== 1'b1 || dm_din !== 32'h1122CCDD || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL partial_merge: we=%b din=%h ack1=%b required 1 1122ccdd 0",
               dm_we, dm_din, m1_ack);
    end
    step();
    checks++;
    if (m1_ack !== 1'b1 || dm_we !== 1'b0 || mem[5] !== 32'h1122CCDD) begin
      errors++;
      $display("FAIL partial_ack: ack1=%b we=%b mem5=%h required 1 0 1122ccdd",
               m1_ack, dm_we, mem[5]);
    end
    m1_req = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int n_ack;
    int last_cyc;
    n_ack = 0;
    last_cyc = 0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd4;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 10'd5;
    for (int cyc = 1; cyc <= 30 && n_ack < 6; cyc++) begin
      step();
      if (m0_ack && m1_ack) begin
        checks++; errors++;
        $display("FAIL rr_overlap: both acks high at cycle %0d required one", cyc);
      end else if (m0_ack || m1_ack) begin
        checks++;
        if (m1_ack !== logic'(n_ack % 2)) begin
          errors++;
          $display("FAIL rr_order: ack %0d went to m%0d required m%0d",
                   n_ack, m1_ack, n_ack % 2);
        end
        checks++;
        if (n_ack > 0 && cyc - last_cyc != 3) begin
          errors++;
          $display("FAIL rr_spacing: ack %0d spacing %0d required 3", n_ack, cyc - last_cyc);
        end
        checks++;
        if (m0_ack && m0_rdata !== 32'hDEADBEEF || m1_ack && m1_rdata !== 32'h1122CCDD) begin
          errors++;
          $display("FAIL rr_rdata: ack %0d rdata=%h required %h", n_ack, m0_rdata,
                   m0_ack ? 32'hDEADBEEF : 32'h1122CCDD);
        end
        last_cyc = cyc;
        n_ack++;
      end
    end
    checks++;
    if (n_ack != 6) begin
      errors++;
      $display("FAIL rr_count: saw %0d acks required 6", n_ack);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic saw_bad;
    saw_bad = 1'b0;
    preload(10'd5, 32'h11223344);
    m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'b0011; m1_addr = 10'd5; m1_wdata = 32'hAABBCCDD;
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (dm_we !== 1'b0 || m1_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_async: we=%b ack1=%b required 0 0", dm_we, m1_ack);
    end
    m1_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (dm_we || m0_ack || m1_ack) saw_bad = 1'b1;
    end
    rst_n = 1'b1;
    step();
    if (dm_we || m0_ack || m1_ack) saw_bad = 1'b1;
    checks++;
    if (saw_bad !== 1'b0 || mem[5] !== 32'h11223344) begin
      errors++;
      $display("FAIL reset_mid_mem: activity=%b mem5=%h required 0 11223344", saw_bad, mem[5]);
    end
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 10'd5;
    step(); step();
    checks++;
    if (m0_ack !== 1'b1 || m0_rdata !== 32'h11223344) begin
      errors++;
      $display("FAIL reset_mid_recover: ack0=%b rdata=%h required 1 11223344", m0_ack, m0_rdata);
    end
    m0_req = 1'b0;
    step();
  endtask

  task automatic test_be_zero();
    logic saw_we;
    saw_we = 1'b0;
    preload(10'd7, 32'hCAFEF00D);
    m0_req = 1'b1; m0_we = 1'b1; m0_be = 4'b0000; m0_addr = 10'd7; m0_wdata = 32'h12345678;
    step();
    if (dm_we) saw_we = 1'b1;
    step();
    if (dm_we) saw_we = 1'b1;
    checks++;
    if (m0_ack !== 1'b1 || saw_we !== 1'b0) begin
      errors++;
      $display("FAIL be_zero_ack: ack0=%b saw_we=%b required 1 0", m0_ack, saw_we);
    end
    m0_req = 1'b0;
    step();
    checks++;
    if (mem[7] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL be_zero_mem: mem7=%h required cafef00d", mem[7]);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    rst_n = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_be = '0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_be = '0; m1_addr = '0; m1_wdata = '0;
    @(negedge clk);
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_round_robin();
    test_reset_mid();
    test_be_zero();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
